// File: rtl/exec_pkg.sv
// rtl/exec_pkg.sv - shared op codes, FSM states and defaults for the execute stage
// Contents:
//   XLEN_DEFAULT  default datapath width
//   exec_op_t     5-bit operation code presented by decode
//   exec_state_t  execute-stage sequencing states
//   is_muldiv()   true for the iterative multiply/divide ops
package exec_pkg;

  localparam int XLEN_DEFAULT = 32;

  typedef enum logic [4:0] {
    OP_ADD    = 5'd0,
    OP_SUB    = 5'd1,
    OP_SLL    = 5'd2,
    OP_SLT    = 5'd3,
    OP_SLTU   = 5'd4,
    OP_XOR    = 5'd5,
    OP_SRL    = 5'd6,
    OP_SRA    = 5'd7,
    OP_OR     = 5'd8,
    OP_AND    = 5'd9,
    OP_BEQ    = 5'd10,
    OP_BNE    = 5'd11,
    OP_BLT    = 5'd12,
    OP_BGE    = 5'd13,
    OP_BLTU   = 5'd14,
    OP_BGEU   = 5'd15,
    OP_JAL    = 5'd16,
    OP_JALR   = 5'd17,
    OP_MUL    = 5'd18,
    OP_MULH   = 5'd19,
    OP_MULHSU = 5'd20,
    OP_MULHU  = 5'd21,
    OP_DIV    = 5'd22,
    OP_DIVU   = 5'd23,
    OP_REM    = 5'd24,
    OP_REMU   = 5'd25,
    OP_UNDEF  = 5'd31
  } exec_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } exec_state_t;

  function automatic logic is_muldiv(input exec_op_t op);
    return (op >= OP_MUL) && (op <= OP_REMU);
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// rtl/muldiv_iter.sv - iterative shift-add multiplier / restoring divider, one bit per cycle
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   flush_i      abandon the current operation
//   start_i      latch op/operands and begin XLEN iterations
//   op_i         muldiv operation (exec_op_t)
//   a_i, b_i     multiplicand/dividend and multiplier/divisor
//   done_o       high during the final iteration cycle
//   result_o     result, valid from the cycle after done_o until the next start
module muldiv_iter
  import exec_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush_i,
  input  logic            start_i,
  input  exec_op_t        op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int CW = $clog2(XLEN);

  logic              r_busy;
  logic [CW-1:0]     r_cnt;
  // Multiply: {partial product, remaining multiplier bits}.
  // Divide:   {partial remainder, dividend bits shifting into quotient}.
  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_b;
  logic              r_is_div;
  logic              r_hi;
  logic              r_rem;
  logic              r_qneg;
  logic              r_rneg;
  logic              r_dz;

  logic              w_a_signed;
  logic              w_b_signed;
  logic              w_sa;
  logic              w_sb;
  logic [XLEN-1:0]   w_mag_a;
  logic [XLEN-1:0]   w_mag_b;

  always_comb begin
    w_a_signed = (op_i == OP_MULH) || (op_i == OP_MULHSU) || (op_i == OP_DIV) || (op_i == OP_REM);
    w_b_signed = (op_i == OP_MULH) || (op_i == OP_DIV) || (op_i == OP_REM);
    w_sa       = w_a_signed && a_i[XLEN-1];
    w_sb       = w_b_signed && b_i[XLEN-1];
    w_mag_a    = w_sa ? -a_i : a_i;
    w_mag_b    = w_sb ? -b_i : b_i;
  end

  logic [XLEN:0]     w_madd;
  logic [XLEN:0]     w_dshift;
  logic [XLEN:0]     w_dsub;
  logic              w_dge;
  logic [2*XLEN-1:0] w_acc_next;

  always_comb begin
    w_madd   = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_b} : {(XLEN+1){1'b0}});
    w_dshift = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
    w_dsub   = w_dshift - {1'b0, r_b};
    w_dge    = (w_dshift >= {1'b0, r_b});
    if (r_is_div) begin
      // The remainder stays below the divisor, so the difference fits in XLEN bits.
      w_acc_next = w_dge ? {w_dsub[XLEN-1:0], r_acc[XLEN-2:0], 1'b1}
                         : {w_dshift[XLEN-1:0], r_acc[XLEN-2:0], 1'b0};
    end else begin
      w_acc_next = {w_madd, r_acc[XLEN-1:1]};
    end
  end

  assign done_o = r_busy && (r_cnt == CW'(XLEN-1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy   <= 1'b0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_b      <= '0;
      r_is_div <= 1'b0;
      r_hi     <= 1'b0;
      r_rem    <= 1'b0;
      r_qneg   <= 1'b0;
      r_rneg   <= 1'b0;
      r_dz     <= 1'b0;
    end else if (flush_i) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
    end else if (start_i) begin
      r_busy   <= 1'b1;
      r_cnt    <= '0;
      r_acc    <= {{XLEN{1'b0}}, w_mag_a};
      r_b      <= w_mag_b;
      r_is_div <= (op_i >= OP_DIV);
      r_hi     <= (op_i != OP_MUL);
      r_rem    <= (op_i == OP_REM) || (op_i == OP_REMU);
      r_qneg   <= w_sa ^ w_sb;
      r_rneg   <= w_sa;
      r_dz     <= (b_i == '0);
    end else if (r_busy) begin
      r_acc <= w_acc_next;
      r_cnt <= r_cnt + CW'(1);
      if (done_o) r_busy <= 1'b0;
    end
  end

  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quo;
  logic [XLEN-1:0]   w_remv;

  always_comb begin
    w_prod = r_qneg ? -r_acc : r_acc;
    // Divide by zero forces an all-ones quotient whatever the operand signs;
    // the remainder naturally comes out equal to the dividend.
    w_quo  = r_dz ? {XLEN{1'b1}} : (r_qneg ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0]);
    w_remv = r_rneg ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];
    if (r_is_div) result_o = r_rem ? w_remv : w_quo;
    else          result_o = r_hi ? w_prod[2*XLEN-1:XLEN] : w_prod[XLEN-1:0];
  end

endmodule

// File: rtl/execute_pipe.sv
// rtl/execute_pipe.sv - RV32I/RV64I execute stage with handshake, branch resolution and flush
// Build option: EXECUTE_MULDIV_EN adds the iterative multiply/divide unit.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   flush_i                 kill in-flight and pending op
//   in_valid_i/in_ready_o   decode-side handshake
//   op_i, oper1_i, oper2_i  operation and operands
//   pc_i, br_off_i          instruction address and branch/jump offset
//   rd_sel_i                destination register
//   out_valid_o/out_ready_i memory-side handshake
//   result_o, rd_sel_o      result and destination register
//   br_taken_o, br_target_o branch/jump resolution
//   illegal_o               unsupported op
module execute_pipe
  import exec_pkg::*;
#(
  parameter int XLEN   = XLEN_DEFAULT,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [4:0]        op_i,
  input  logic [XLEN-1:0]   oper1_i,
  input  logic [XLEN-1:0]   oper2_i,
  input  logic [XLEN-1:0]   pc_i,
  input  logic [XLEN-1:0]   br_off_i,
  input  logic [REG_AW-1:0] rd_sel_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [XLEN-1:0]   result_o,
  output logic [REG_AW-1:0] rd_sel_o,
  output logic              br_taken_o,
  output logic [XLEN-1:0]   br_target_o,
  output logic              illegal_o
);

  localparam int              SHW     = $clog2(XLEN);
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  exec_op_t          w_op;
  logic [SHW-1:0]    w_sh;
  logic [XLEN-1:0]   w_pc4;
  logic [XLEN-1:0]   w_br_tgt;
  logic [XLEN-1:0]   w_jalr_sum;
  logic              w_eq;
  logic              w_lt;
  logic              w_ltu;
  logic [XLEN-1:0]   w_alu_res;
  logic              w_alu_taken;
  logic [XLEN-1:0]   w_alu_tgt;
  logic              w_alu_illegal;

  logic              r_out_valid;
  logic [XLEN-1:0]   r_result;
  logic [REG_AW-1:0] r_rd;
  logic              r_taken;
  logic [XLEN-1:0]   r_target;
  logic              r_illegal;

  logic              w_out_free;
  logic              w_accept;
  logic              w_load;
  logic [XLEN-1:0]   w_nx_result;
  logic [REG_AW-1:0] w_nx_rd;
  logic              w_nx_taken;
  logic [XLEN-1:0]   w_nx_target;
  logic              w_nx_illegal;

  assign w_op       = exec_op_t'(op_i);
  assign w_sh       = oper2_i[SHW-1:0];
  assign w_pc4      = pc_i + PC_STEP;
  assign w_br_tgt   = pc_i + br_off_i;
  assign w_jalr_sum = oper1_i + oper2_i;
  assign w_eq       = (oper1_i == oper2_i);
  assign w_lt       = ($signed(oper1_i) < $signed(oper2_i));
  assign w_ltu      = (oper1_i < oper2_i);

  always_comb begin
    w_alu_res     = '0;
    w_alu_taken   = 1'b0;
    w_alu_tgt     = '0;
    w_alu_illegal = 1'b0;
    case (w_op)
      OP_ADD:  w_alu_res = oper1_i + oper2_i;
      OP_SUB:  w_alu_res = oper1_i - oper2_i;
      OP_SLL:  w_alu_res = oper1_i << w_sh;
      OP_SLT:  w_alu_res = {{(XLEN-1){1'b0}}, w_lt};
      OP_SLTU: w_alu_res = {{(XLEN-1){1'b0}}, w_ltu};
      OP_XOR:  w_alu_res = oper1_i ^ oper2_i;
      OP_SRL:  w_alu_res = oper1_i >> w_sh;
      OP_SRA:  w_alu_res = $unsigned($signed(oper1_i) >>> w_sh);
      OP_OR:   w_alu_res = oper1_i | oper2_i;
      OP_AND:  w_alu_res = oper1_i & oper2_i;
      OP_BEQ:  begin w_alu_taken = w_eq;   w_alu_tgt = w_br_tgt; end
      OP_BNE:  begin w_alu_taken = !w_eq;  w_alu_tgt = w_br_tgt; end
      OP_BLT:  begin w_alu_taken = w_lt;   w_alu_tgt = w_br_tgt; end
      OP_BGE:  begin w_alu_taken = !w_lt;  w_alu_tgt = w_br_tgt; end
      OP_BLTU: begin w_alu_taken = w_ltu;  w_alu_tgt = w_br_tgt; end
      OP_BGEU: begin w_alu_taken = !w_ltu; w_alu_tgt = w_br_tgt; end
      OP_JAL: begin
        w_alu_res   = w_pc4;
        w_alu_taken = 1'b1;
        w_alu_tgt   = w_br_tgt;
      end
      OP_JALR: begin
        w_alu_res   = w_pc4;
        w_alu_taken = 1'b1;
        w_alu_tgt   = {w_jalr_sum[XLEN-1:1], 1'b0};
      end
      // Undefined codes, and muldiv codes when the unit is not built.
      default: w_alu_illegal = 1'b1;
    endcase
  end

  assign w_out_free = !r_out_valid || out_ready_i;
  assign w_accept   = in_valid_i && in_ready_o;

`ifdef EXECUTE_MULDIV_EN
  exec_state_t       r_state;
  logic [REG_AW-1:0] r_md_rd;
  logic              w_md_start;
  logic              w_md_done;
  logic [XLEN-1:0]   w_md_result;
  logic              w_in_done;

  assign in_ready_o = !flush_i && (r_state == ST_IDLE) && w_out_free;
  assign w_md_start = w_accept && is_muldiv(w_op);
  assign w_in_done  = (r_state == ST_DONE);
  // In DONE in_ready_o is low, so the two load sources never coincide.
  assign w_load     = (w_accept && !is_muldiv(w_op)) || (w_in_done && w_out_free);

  always_comb begin
    w_nx_result  = w_in_done ? w_md_result : w_alu_res;
    w_nx_rd      = w_in_done ? r_md_rd     : rd_sel_i;
    w_nx_taken   = w_in_done ? 1'b0        : w_alu_taken;
    w_nx_target  = w_in_done ? '0          : w_alu_tgt;
    w_nx_illegal = w_in_done ? 1'b0        : w_alu_illegal;
  end

  muldiv_iter #(
    .XLEN(XLEN)
  ) u_muldiv (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush_i  (flush_i),
    .start_i  (w_md_start),
    .op_i     (w_op),
    .a_i      (oper1_i),
    .b_i      (oper2_i),
    .done_o   (w_md_done),
    .result_o (w_md_result)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_md_rd <= '0;
    end else if (flush_i) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_md_start) begin
            r_state <= (w_op >= OP_DIV) ? ST_DIV : ST_MUL;
            r_md_rd <= rd_sel_i;
          end
        end
        ST_MUL, ST_DIV: if (w_md_done) r_state <= ST_DONE;
        ST_DONE:        if (w_out_free) r_state <= ST_IDLE;
        default:        r_state <= ST_IDLE;
      endcase
    end
  end
`else
  assign in_ready_o   = !flush_i && w_out_free;
  assign w_load       = w_accept;
  assign w_nx_result  = w_alu_res;
  assign w_nx_rd      = rd_sel_i;
  assign w_nx_taken   = w_alu_taken;
  assign w_nx_target  = w_alu_tgt;
  assign w_nx_illegal = w_alu_illegal;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_rd        <= '0;
      r_taken     <= 1'b0;
      r_target    <= '0;
      r_illegal   <= 1'b0;
    end else if (flush_i) begin
      r_out_valid <= 1'b0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_result    <= w_nx_result;
      r_rd        <= w_nx_rd;
      r_taken     <= w_nx_taken;
      r_target    <= w_nx_target;
      r_illegal   <= w_nx_illegal;
    end else if (out_ready_i) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid_o = r_out_valid;
  assign result_o    = r_result;
  assign rd_sel_o    = r_rd;
  assign br_taken_o  = r_taken;
  assign br_target_o = r_target;
  assign illegal_o   = r_illegal;

endmodule

// File: doc/execute_pipe.md
Name: execute_pipe

Overview:
- Parametrised execute stage for the RISC-V core; successor to the single-cycle execute stage.
- Sits between decode and memory stages.
- Adds a valid/ready handshake on both sides, the full RV32I ALU op set, branch resolution, and flush.
- Adds an optional iterative multi-cycle multiply/divide unit; back-pressure stalls decode while it runs.

Parameters:
- XLEN, 32, datapath width in bits (32 or 64).
- REG_AW, 5, register-index width.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- flush_i  input  1  kill in-flight and pending op (branch mispredict/trap)
- in_valid_i  input  1  decode presents an op
- in_ready_o  output  1  stage accepts op this cycle
- op_i  input  5  operation, exec_op_t from shared package
- oper1_i  input  XLEN  operand 1 (rs1 or pc)
- oper2_i  input  XLEN  operand 2 (rs2 or sign-extended imm)
- pc_i  input  XLEN  instruction address
- br_off_i  input  XLEN  sign-extended branch/jump offset
- rd_sel_i  input  REG_AW  destination register
- out_valid_o  output  1  result registered and valid
- out_ready_i  input  1  memory stage consumes result
- result_o  output  XLEN  ALU/muldiv result (pc+4 for JAL/JALR)
- rd_sel_o  output  REG_AW  destination register
- br_taken_o  output  1  branch/jump taken, valid with out_valid_o
- br_target_o  output  XLEN  taken target
- illegal_o  output  1  unsupported op, valid with out_valid_o

Behaviour:
- Reset (async): all outputs 0; state IDLE. in_ready_o=1 after reset deasserts.
- Accept when in_valid_i && in_ready_o.
- in_ready_o = (state==IDLE) && (!out_valid_o || out_ready_i).
- Single-cycle ops: ADD SUB SLL SLT SLTU XOR SRL SRA OR AND, BEQ BNE BLT BGE BLTU BGEU, JAL, JALR.
  - Result registered on the edge following accept; latency 1.
  - Full throughput when out_ready_i=1.
- Shift amount = oper2_i[log2(XLEN)-1:0]. Arithmetic wraps modulo 2^XLEN.
- Branches:
  - result_o=0; br_taken_o per compare.
  - br_target_o = pc_i + br_off_i.
- JAL:
  - result_o = pc_i+4; br_taken_o=1; br_target_o = pc_i + br_off_i.
- JALR:
  - result_o = pc_i+4; br_taken_o=1.
  - br_target_o = (oper1_i+oper2_i) with bit 0 cleared.
- Output register holds contents while out_valid_o && !out_ready_i.
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE -> MUL/DIV on accepting a muldiv op; operands and rd are latched.
  - MUL/DIV iterate one bit per cycle for XLEN cycles (counter 0..XLEN-1), then -> DONE.
  - DONE loads the output register when (!out_valid_o || out_ready_i), then -> IDLE.
  - Muldiv latency is XLEN+1 cycles accept-to-out_valid_o, or longer under back-pressure.
- Muldiv op encoding:
  - MUL, MULH, MULHSU, MULHU: shift-add on operand magnitudes with sign fix-up at the end.
  - DIV, DIVU, REM, REMU: restoring division.
- Divide by zero: quotient all-ones, remainder = dividend. Completes in normal XLEN cycles.
- Signed overflow (min / -1): quotient = min, remainder = 0.
- flush_i, highest priority, synchronous:
  - Next edge: out_valid_o=0 and state=IDLE.
  - Iteration counter is cleared.
  - A simultaneously presented input is not accepted (in_ready_o forced 0 while flush_i=1).
- Async reset mid-iteration aborts the op; no result is produced.

Optional Feature:
- Macro EXECUTE_MULDIV_EN.
- Defined: muldiv unit and MUL/DIV states present as above.
- Undefined:
  - Muldiv unit and MUL/DIV states are not built.
  - Muldiv ops complete in one cycle with result_o=0 and illegal_o=1.
  - in_ready_o = !out_valid_o || out_ready_i.

Decomposition:
- Package exec_pkg holds:
  - exec_op_t enum: 5-bit, all ALU/branch/jump/muldiv codes plus OP_UNDEF.
  - exec_state_t enum.
  - XLEN default constant.
- Sub-module muldiv_iter: iterative multiplier/divider with start/done handshake.
  - Instantiated only under EXECUTE_MULDIV_EN.
- Combinational ALU/branch compare stays in execute_pipe.

Test Plan:
- ADD 0x7FFFFFFF+1, then SRA 0x80000000>>4, back-to-back with out_ready_i=1 -> results 0x80000000, then 0xF8000000, on consecutive cycles after 1-cycle latency.
- BLT pc=0x100, oper1=-1, oper2=0, br_off=0x20 -> br_taken_o=1, br_target_o=0x120. JALR oper1=0x203, oper2=0 -> target 0x202, result 0x104.
- MULH 0x80000000*0x80000000 -> result 0x40000000 after 33 cycles; in_ready_o=0 throughout.
- DIV 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5; DIV 0x80000000/-1 -> 0x80000000; REM same operands -> 0.
- out_ready_i=0 for 3 cycles with valid result -> result_o stable, in_ready_o=0. Release -> next op accepted same cycle.
- flush_i at iteration 10 of DIVU -> out_valid_o=0 next cycle, state IDLE, no result emitted. Build without EXECUTE_MULDIV_EN: MUL -> illegal_o=1, result 0, latency 1.
